// File: rtl/ec_pkg.sv
// Shared constants and encodings for the 8-bit accumulator processor datapath.
package ec_pkg;
  localparam int EC_DATA_W = 8;
  localparam int EC_ADDR_W = 5;
  localparam int EC_OP_W   = EC_DATA_W - EC_ADDR_W;

  typedef enum logic [2:0] {
    LOAD  = 3'b000,
    STORE = 3'b001,
    ADD   = 3'b010,
    SUB   = 3'b011,
    INPUT = 3'b100,
    JZ    = 3'b101,
    JPOS  = 3'b110,
    HALT  = 3'b111
  } opcode_e;

  typedef enum logic [1:0] {
    ASEL_ALU   = 2'b00,
    ASEL_INPUT = 2'b01,
    ASEL_MEM   = 2'b10,
    ASEL_ZERO  = 2'b11
  } asel_e;
endpackage

// File: rtl/ec_ram.sv
// Unified program/data RAM: one registered read port, one write port where the
// boot strobe overrides the CPU store. Writes are blocked while reset is held.
module ec_ram
  import ec_pkg::*;
#(
  parameter int DATA_W   = EC_DATA_W,
  parameter int ADDR_W   = EC_ADDR_W,
  parameter     MEM_INIT = ""
) (
  input  logic              CLOCK_50,
  input  logic              reset,
  input  logic [ADDR_W-1:0] raddr,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic              prog_we,
  input  logic [ADDR_W-1:0] prog_addr,
  input  logic [DATA_W-1:0] prog_data,
  output logic [DATA_W-1:0] rdata
);
  logic [DATA_W-1:0] mem [2**ADDR_W];

  // Nonblocking write and read in one block give read-old-data on a collision.
  always_ff @(posedge CLOCK_50 or negedge reset) begin
    if (!reset) begin
      rdata <= '0;
    end else begin
      rdata <= mem[raddr];
      if (prog_we) mem[prog_addr] <= prog_data;
      else if (we) mem[waddr] <= wdata;
    end
  end
endmodule

// File: rtl/ec_datapath.sv
// Accumulator processor datapath: PC, IR, A, address/source muxes, add/sub and
// status flags, driven cycle by cycle by the external control unit.
module ec_datapath
  import ec_pkg::*;
#(
  parameter int DATA_W   = EC_DATA_W,
  parameter int ADDR_W   = EC_ADDR_W,
  parameter     MEM_INIT = ""
) (
  input  logic                     CLOCK_50,
  input  logic                     reset,
  input  logic                     IRload,
  input  logic                     JMPmux,
  input  logic                     PCload,
  input  logic                     Meminst,
  input  logic                     MemWr,
  input  logic [1:0]               Asel,
  input  logic                     Aload,
  input  logic                     Sub,
  input  logic [DATA_W-1:0]        Input,
  input  logic                     prog_we,
  input  logic [ADDR_W-1:0]        prog_addr,
  input  logic [DATA_W-1:0]        prog_data,
  output logic [DATA_W-ADDR_W-1:0] IR,
  output logic                     Aeq0,
  output logic                     Apos,
  output logic [DATA_W-1:0]        Output,
  output logic [ADDR_W-1:0]        PC_out
);
  logic [ADDR_W-1:0] pc, ir_addr, mem_addr, pc_next;
  logic [DATA_W-1:0] ir, a, rdata, alu, a_next;

  assign ir_addr  = ir[ADDR_W-1:0];
  assign mem_addr = Meminst ? ir_addr : pc;
  assign pc_next  = JMPmux ? ir_addr : pc + ADDR_W'(1);
  assign alu      = Sub ? a + ~rdata + DATA_W'(1) : a + rdata;

  always_comb begin
    a_next = a;
    case (asel_e'(Asel))
      ASEL_ALU:   a_next = alu;
      ASEL_INPUT: a_next = Input;
      ASEL_MEM:   a_next = rdata;
      ASEL_ZERO:  a_next = '0;
      default:    a_next = a;
    endcase
  end

  // All enables sample pre-edge values, so simultaneous loads compose cleanly.
  always_ff @(posedge CLOCK_50 or negedge reset) begin
    if (!reset) begin
      pc <= '0;
      ir <= '0;
      a  <= '0;
    end else begin
      if (PCload) pc <= pc_next;
      if (IRload) ir <= rdata;
      if (Aload)  a  <= a_next;
    end
  end

  ec_ram #(
    .DATA_W   (DATA_W),
    .ADDR_W   (ADDR_W),
    .MEM_INIT (MEM_INIT)
  ) u_ram (
    .CLOCK_50  (CLOCK_50),
    .reset     (reset),
    .raddr     (mem_addr),
    .we        (MemWr),
    .waddr     (ir_addr),
    .wdata     (a),
    .prog_we   (prog_we),
    .prog_addr (prog_addr),
    .prog_data (prog_data),
    .rdata     (rdata)
  );

  assign IR     = ir[DATA_W-1:ADDR_W];
  assign Aeq0   = (a == '0);
  assign Apos   = !a[DATA_W-1] && (a != '0);
  assign Output = a;
  assign PC_out = pc;
endmodule

// File: tb/tb_ec_datapath.sv
// Self-checking bench for ec_datapath: vector table for the A-source paths plus
// hand-written fetch, store, jump and reset sequences, checked via a scoreboard.
module tb_ec_datapath;
  import ec_pkg::*;

  logic       CLOCK_50 = 1'b0;
  logic       reset;
  logic       IRload, JMPmux, PCload, Meminst, MemWr, Aload, Sub, prog_we;
  logic [1:0] Asel;
  logic [7:0] Input, prog_data, Output;
  logic [4:0] prog_addr, PC_out;
  logic [2:0] IR;
  logic       Aeq0, Apos;

  int checks = 0;
  int errors = 0;
  logic [17:0] exp_q[$];

  typedef struct {
    logic [7:0] a_init;
    logic [7:0] m;
    logic [1:0] asel;
    logic       sub;
    logic [7:0] inp;
    logic       aload;
    logic [7:0] exp_a;
    logic       eq0;
    logic       pos;
  } vec_t;
  vec_t vecs[12];

  always #10 CLOCK_50 = ~CLOCK_50;

  ec_datapath dut (
    .CLOCK_50  (CLOCK_50),
    .reset     (reset),
    .IRload    (IRload),
    .JMPmux    (JMPmux),
    .PCload    (PCload),
    .Meminst   (Meminst),
    .MemWr     (MemWr),
    .Asel      (Asel),
    .Aload     (Aload),
    .Sub       (Sub),
    .Input     (Input),
    .prog_we   (prog_we),
    .prog_addr (prog_addr),
    .prog_data (prog_data),
    .IR        (IR),
    .Aeq0      (Aeq0),
    .Apos      (Apos),
    .Output    (Output),
    .PC_out    (PC_out)
  );

  task automatic tick();
    @(posedge CLOCK_50);
    #1;
  endtask

  task automatic idle();
    IRload = 0; JMPmux = 0; PCload = 0; Meminst = 0; MemWr = 0;
    Asel = ASEL_ALU; Aload = 0; Sub = 0; Input = '0;
    prog_we = 0; prog_addr = '0; prog_data = '0;
  endtask

  task automatic prog(input logic [4:0] addr, input logic [7:0] data);
    prog_we = 1; prog_addr = addr; prog_data = data;
    tick();
    prog_we = 0;
  endtask

  task automatic set_a(input logic [7:0] v);
    Asel = ASEL_INPUT; Input = v; Aload = 1;
    tick();
    Aload = 0;
  endtask

  task automatic expect_state(input logic [2:0] op, input logic eq0, input logic pos,
                              input logic [4:0] pc, input logic [7:0] a);
    exp_q.push_back({op, eq0, pos, pc, a});
  endtask

  task automatic check(input string name);
    logic [17:0] act, exp;
    act = {IR, Aeq0, Apos, PC_out, Output};
    checks++;
    if (exp_q.size() == 0) begin
      errors++;
      $display("FAIL %s: no expected entry, got %h", name, act);
    end else begin
      exp = exp_q.pop_front();
      if (act !== exp) begin
        errors++;
        $display("FAIL %s: got op=%b eq0=%b pos=%b pc=%0d a=%h, want op=%b eq0=%b pos=%b pc=%0d a=%h",
                 name, act[17:15], act[14], act[13], act[12:8], act[7:0],
                 exp[17:15], exp[14], exp[13], exp[12:8], exp[7:0]);
      end
    end
  endtask

  initial begin
    vecs[0]  = '{8'h03, 8'h0A, ASEL_ALU,   1'b0, 8'h00, 1'b1, 8'h0D, 1'b0, 1'b1};
    vecs[1]  = '{8'h03, 8'h0A, ASEL_ALU,   1'b1, 8'h00, 1'b1, 8'hF9, 1'b0, 1'b0};
    vecs[2]  = '{8'h05, 8'h05, ASEL_ALU,   1'b1, 8'h00, 1'b1, 8'h00, 1'b1, 1'b0};
    vecs[3]  = '{8'hFF, 8'h01, ASEL_ALU,   1'b0, 8'h00, 1'b1, 8'h00, 1'b1, 1'b0};
    vecs[4]  = '{8'h80, 8'h01, ASEL_ALU,   1'b1, 8'h00, 1'b1, 8'h7F, 1'b0, 1'b1};
    vecs[5]  = '{8'h12, 8'h34, ASEL_INPUT, 1'b0, 8'h00, 1'b1, 8'h00, 1'b1, 1'b0};
    vecs[6]  = '{8'h12, 8'h34, ASEL_INPUT, 1'b1, 8'h01, 1'b1, 8'h01, 1'b0, 1'b1};
    vecs[7]  = '{8'h12, 8'h34, ASEL_INPUT, 1'b0, 8'h80, 1'b1, 8'h80, 1'b0, 1'b0};
    vecs[8]  = '{8'h12, 8'h34, ASEL_MEM,   1'b1, 8'h00, 1'b1, 8'h34, 1'b0, 1'b1};
    vecs[9]  = '{8'h12, 8'h34, ASEL_ZERO,  1'b0, 8'h55, 1'b1, 8'h00, 1'b1, 1'b0};
    vecs[10] = '{8'h12, 8'h34, ASEL_ALU,   1'b0, 8'h00, 1'b0, 8'h12, 1'b0, 1'b1};
    vecs[11] = '{8'h00, 8'h9C, ASEL_MEM,   1'b0, 8'h00, 1'b1, 8'h9C, 1'b0, 1'b0};

    // Reset and RAM preload.
    idle();
    reset = 0;
    tick(); tick();
    reset = 1;
    tick();
    prog(5'd0, 8'h45);
    prog(5'd5, 8'h0A);
    prog(5'd9, 8'h3C);

    // Random controls, including write strobes, while reset is held.
    reset = 0;
    for (int i = 0; i < 6; i++) begin
      IRload = 1'($urandom_range(0, 1)); JMPmux = 1'($urandom_range(0, 1));
      PCload = 1'($urandom_range(0, 1)); Meminst = 1'($urandom_range(0, 1));
      MemWr = 1'($urandom_range(0, 1)); Asel = 2'($urandom_range(0, 3));
      Aload = 1'($urandom_range(0, 1)); Sub = 1'($urandom_range(0, 1));
      Input = 8'($urandom_range(1, 255)); prog_we = 1'($urandom_range(0, 1));
      prog_addr = 5'($urandom_range(0, 31)); prog_data = 8'($urandom_range(0, 255));
      tick();
      expect_state(3'b000, 1'b1, 1'b0, 5'd0, 8'h00);
      check($sformatf("reset_hold%0d", i));
    end
    idle();
    reset = 1;
    tick();
    expect_state(3'b000, 1'b1, 1'b0, 5'd0, 8'h00);
    check("reset_release");

    // Fetch and decode RAM[0]=45 (proves the preload survived reset).
    Meminst = 0;
    tick();
    IRload = 1; PCload = 1;
    tick();
    IRload = 0; PCload = 0;
    expect_state(3'b010, 1'b1, 1'b0, 5'd1, 8'h00);
    check("fetch_decode");

    // Operand from IR[4:0]=5.
    Meminst = 1;
    tick();
    Asel = ASEL_MEM; Aload = 1;
    tick();
    Aload = 0;
    expect_state(3'b010, 1'b0, 1'b1, 5'd1, 8'h0A);
    check("load_operand");

    // A-source vector table.
    for (int i = 0; i < 12; i++) begin
      Meminst = 1;
      prog(5'd5, vecs[i].m);
      set_a(vecs[i].a_init);
      Asel = vecs[i].asel; Sub = vecs[i].sub; Input = vecs[i].inp; Aload = vecs[i].aload;
      tick();
      Aload = 0; Sub = 0;
      expect_state(3'b010, vecs[i].eq0, vecs[i].pos, 5'd1, vecs[i].exp_a);
      check($sformatf("vec%0d", i));
    end

    // Store with read-during-write returning old data.
    idle();
    prog(5'd1, 8'h29);
    tick();
    IRload = 1;
    tick();
    IRload = 0;
    expect_state(3'b001, 1'b0, 1'b0, 5'd1, 8'h9C);
    check("ir_store");
    Meminst = 1;
    set_a(8'h7F);
    MemWr = 1;
    tick();
    MemWr = 0; Asel = ASEL_MEM; Aload = 1;
    tick();
    expect_state(3'b001, 1'b0, 1'b1, 5'd1, 8'h3C);
    check("store_read_old");
    tick();
    Aload = 0;
    expect_state(3'b001, 1'b0, 1'b1, 5'd1, 8'h7F);
    check("store_read_new");

    // prog_we overrides a simultaneous MemWr.
    MemWr = 1; prog_we = 1; prog_addr = 5'd9; prog_data = 8'h11;
    tick();
    MemWr = 0; prog_we = 0; Asel = ASEL_MEM; Aload = 1;
    tick();
    expect_state(3'b001, 1'b0, 1'b1, 5'd1, 8'h7F);
    check("prog_read_old");
    tick();
    Aload = 0;
    expect_state(3'b001, 1'b0, 1'b1, 5'd1, 8'h11);
    check("prog_priority");

    // Jumps and PC wrap.
    idle();
    prog(5'd1, 8'h1F);
    tick();
    IRload = 1;
    tick();
    IRload = 0; PCload = 1; JMPmux = 1;
    tick();
    expect_state(3'b000, 1'b0, 1'b1, 5'd31, 8'h11);
    check("jump_31");
    JMPmux = 0;
    tick();
    PCload = 0;
    expect_state(3'b000, 1'b0, 1'b1, 5'd0, 8'h11);
    check("pc_wrap");
    prog(5'd0, 8'hB4);
    tick();
    IRload = 1;
    tick();
    IRload = 0; PCload = 1; JMPmux = 1;
    tick();
    expect_state(3'b101, 1'b0, 1'b1, 5'd20, 8'h11);
    check("jump_20");
    JMPmux = 0;
    tick();
    PCload = 0;
    expect_state(3'b101, 1'b0, 1'b1, 5'd21, 8'h11);
    check("pc_inc");
    prog(5'd21, 8'hE3);
    tick();
    IRload = 1; PCload = 1; JMPmux = 1;
    tick();
    IRload = 0; PCload = 0; JMPmux = 0;
    expect_state(3'b111, 1'b0, 1'b1, 5'd20, 8'h11);
    check("jump_old_ir");

    // Asynchronous reset mid-store: must clear at once and not write.
    Meminst = 1;
    set_a(8'h42);
    MemWr = 1;
    @(negedge CLOCK_50);
    reset = 0;
    #1;
    expect_state(3'b000, 1'b1, 1'b0, 5'd0, 8'h00);
    check("async_reset");
    tick(); tick();
    idle();
    reset = 1;
    tick();
    Asel = ASEL_MEM; Aload = 1;
    tick();
    Aload = 0;
    expect_state(3'b000, 1'b0, 1'b0, 5'd0, 8'hB4);
    check("no_write_in_reset");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
